wb_stage_regfile: RTL and testbench

Writeback stage fused with the 32-entry integer register file for the RV32I pipeline. It consumes the MEM/WB pipeline register outputs, selects and formats the writeback value (ALU result, sign/zero-extended load data, or PC+4), and commits it to the register file. It serves the two decode-stage read ports with same-cycle write-through bypass, exports the writeback triple for forwarding, and keeps a 64-bit retired-instruction counter.

---
 rtl/wb_stage_regfile.sv | 124 ++++++++++++
 tb/tb_wb_stage_regfile.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/wb_stage_regfile.sv
// RV32I writeback stage fused with the 32-entry integer register file.
// Formats the writeback value, commits it, serves two bypassed read ports, counts retirements.

module wb_rf_read_port #(
  parameter int size = 32
) (
  input  logic                   reset,
  input  logic [4:0]             addr,
  input  logic                   wb_we,
  input  logic [4:0]             wb_rd,
  input  logic [size-1:0]        wb_data,
  input  logic [31:0][size-1:0]  regs,
  output logic [size-1:0]        data
);
  always_comb begin
    data = '0;
    if (reset && addr != 5'd0) begin
      if (wb_we && addr == wb_rd) data = wb_data;
      else                        data = regs[addr];
    end
  end
endmodule

module wb_stage_regfile #(
  parameter int size = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [size-1:0]   pc_wb,
  input  logic [size-1:0]   pc_adder_out_wb,
  input  logic [size-1:0]   alu_out_wb,
  input  logic [size-1:0]   dmem_out_wb,
  input  logic [size-1:0]   instruction_wb,
  input  logic              reg_wr_en_wb,
  input  logic [1:0]        wb_sel_wb,
  input  logic [4:0]        rs1_addr,
  input  logic [4:0]        rs2_addr,
  output logic [size-1:0]   rs1_data,
  output logic [size-1:0]   rs2_data,
  output logic [size-1:0]   wb_data,
  output logic [4:0]        wb_rd,
  output logic              wb_we,
  output logic [63:0]       retire_count
);
  localparam int NUM_PORTS = 2;

  logic [31:0][size-1:0]        regs;
  logic [2:0]                   funct3;
  logic [1:0]                   offset;
  logic [7:0]                   ld_byte;
  logic [15:0]                  ld_half;
  logic [size-1:0]              load_data;
  logic [NUM_PORTS-1:0][4:0]      rs_addr;
  logic [NUM_PORTS-1:0][size-1:0] rs_data;
  logic                         unused_trace;

  // pc_wb is carried for trace only
  assign unused_trace = ^pc_wb;

  assign funct3 = instruction_wb[14:12];
  assign wb_rd  = instruction_wb[11:7];
  assign offset = alu_out_wb[1:0];
  assign wb_we  = reg_wr_en_wb && (wb_rd != 5'd0) && reset;

  always_comb begin
    case (offset)
      2'd0:    ld_byte = dmem_out_wb[7:0];
      2'd1:    ld_byte = dmem_out_wb[15:8];
      2'd2:    ld_byte = dmem_out_wb[23:16];
      default: ld_byte = dmem_out_wb[31:24];
    endcase
  end

  // halfword select ignores offset[0]; misalignment is not trapped here
  assign ld_half = offset[1] ? dmem_out_wb[31:16] : dmem_out_wb[15:0];

  always_comb begin
    case (funct3)
      3'b000:  load_data = {{(size-8){ld_byte[7]}}, ld_byte};
      3'b001:  load_data = {{(size-16){ld_half[15]}}, ld_half};
      3'b100:  load_data = {{(size-8){1'b0}}, ld_byte};
      3'b101:  load_data = {{(size-16){1'b0}}, ld_half};
      default: load_data = dmem_out_wb;
    endcase
  end

  always_comb begin
    case (wb_sel_wb)
      2'b00:   wb_data = alu_out_wb;
      2'b01:   wb_data = load_data;
      2'b10:   wb_data = pc_adder_out_wb;
      default: wb_data = '0;
    endcase
  end

  // x0 is never written because wb_we excludes rd == 0
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     regs <= '0;
    else if (wb_we) regs[wb_rd] <= wb_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                         retire_count <= '0;
    else if (instruction_wb != '0)      retire_count <= retire_count + 64'd1;
  end

  assign rs_addr[0] = rs1_addr;
  assign rs_addr[1] = rs2_addr;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    wb_rf_read_port #(.size(size)) u_port (
      .reset   (reset),
      .addr    (rs_addr[g]),
      .wb_we   (wb_we),
      .wb_rd   (wb_rd),
      .wb_data (wb_data),
      .regs    (regs),
      .data    (rs_data[g])
    );
  end

  assign rs1_data = rs_data[0];
  assign rs2_data = rs_data[1];
endmodule

// File: tb/tb_wb_stage_regfile.sv
// Directed bench for wb_stage_regfile: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them.

module tb_wb_stage_regfile;
  logic        clk, reset;
  logic [31:0] pc_wb, pc_adder_out_wb, alu_out_wb, dmem_out_wb, instruction_wb;
  logic        reg_wr_en_wb;
  logic [1:0]  wb_sel_wb;
  logic [4:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data, wb_data;
  logic [4:0]  wb_rd;
  logic        wb_we;
  logic [63:0] retire_count;

  wb_stage_regfile #(.size(32)) dut (
    .clk(clk), .reset(reset), .pc_wb(pc_wb), .pc_adder_out_wb(pc_adder_out_wb),
    .alu_out_wb(alu_out_wb), .dmem_out_wb(dmem_out_wb), .instruction_wb(instruction_wb),
    .reg_wr_en_wb(reg_wr_en_wb), .wb_sel_wb(wb_sel_wb), .rs1_addr(rs1_addr),
    .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_we(wb_we), .retire_count(retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // mask bits: 0 rs1, 1 rs2, 2 wb_data, 3 wb_we, 4 retire_count
  typedef struct {
    string       name;
    logic [4:0]  m;
    logic [31:0] rs1, rs2, wbd;
    logic        we;
    logic [63:0] rc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] rc_m   = 64'd0;

  localparam logic [4:0] ALL = 5'b11111;
  localparam logic [4:0] RD  = 5'b11011;
  localparam logic [4:0] WB  = 5'b11100;

  function automatic logic [31:0] ins(input logic [4:0] rd, input logic [2:0] f3);
    return {17'h0, f3, rd, 7'h03};
  endfunction

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.m[0]) begin
        checks++;
        if (rs1_data !== e.rs1) begin errors++;
          $display("FAIL %s rs1_data got %h want %h", e.name, rs1_data, e.rs1); end
      end
      if (e.m[1]) begin
        checks++;
        if (rs2_data !== e.rs2) begin errors++;
          $display("FAIL %s rs2_data got %h want %h", e.name, rs2_data, e.rs2); end
      end
      if (e.m[2]) begin
        checks++;
        if (wb_data !== e.wbd) begin errors++;
          $display("FAIL %s wb_data got %h want %h", e.name, wb_data, e.wbd); end
      end
      if (e.m[3]) begin
        checks++;
        if (wb_we !== e.we) begin errors++;
          $display("FAIL %s wb_we got %b want %b", e.name, wb_we, e.we); end
      end
      if (e.m[4]) begin
        checks++;
        if (retire_count !== e.rc) begin errors++;
          $display("FAIL %s retire_count got %0d want %0d", e.name, retire_count, e.rc); end
      end
    end
  end

  // One cycle: account for the edge just taken, drive new inputs, queue expectation.
  task automatic step(input string nm, input logic rst_v, input logic [31:0] instr,
                      input logic [1:0] sel, input logic we, input logic [31:0] alu,
                      input logic [31:0] dmem, input logic [31:0] pc4,
                      input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] m,
                      input logic [31:0] e1, input logic [31:0] e2,
                      input logic [31:0] ew, input logic ewe);
    exp_t e;
    @(posedge clk);
    if (reset === 1'b1 && instruction_wb != 32'd0) rc_m = rc_m + 64'd1;
    #1;
    reset = rst_v; instruction_wb = instr; wb_sel_wb = sel; reg_wr_en_wb = we;
    alu_out_wb = alu; dmem_out_wb = dmem; pc_adder_out_wb = pc4; pc_wb = pc4 - 32'd4;
    rs1_addr = a1; rs2_addr = a2;
    if (!rst_v) rc_m = 64'd0;
    e.name = nm; e.m = m; e.rs1 = e1; e.rs2 = e2; e.wbd = ew; e.we = ewe; e.rc = rc_m;
    q.push_back(e);
  endtask

  localparam logic [31:0] DM = 32'h8899AABB;

  initial begin
    reset = 1'b0; pc_wb = '0; pc_adder_out_wb = '0; alu_out_wb = '0; dmem_out_wb = '0;
    instruction_wb = '0; reg_wr_en_wb = 1'b0; wb_sel_wb = '0; rs1_addr = '0; rs2_addr = '0;

    // reset held: write attempt suppressed, every register reads 0
    step("rst_we", 0, ins(5'd5, 3'd0), 2'b00, 1, 32'hDEADBEEF, 0, 0, 5, 5, ALL,
         0, 0, 32'hDEADBEEF, 0);
    for (int i = 0; i < 32; i++)
      step("rst_rd", 0, ins(5'd7, 3'd0), 2'b00, 1, 32'h55, 0, 0, 5'(i), 5'(31 - i), RD,
           0, 0, 0, 0);

    step("byp_x5", 1, ins(5'd5, 3'd0), 2'b00, 1, 32'hDEADBEEF, 0, 0, 5, 0, ALL,
         32'hDEADBEEF, 0, 32'hDEADBEEF, 1);
    step("rd_x5", 1, 32'd0, 2'b00, 0, 0, 0, 0, 5, 5, RD, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);

    step("lb2",  1, ins(5'd6, 3'b000), 2'b01, 0, 32'h102, DM, 0, 0, 0, WB, 0, 0, 32'hFFFFFF99, 0);
    step("lbu2", 1, ins(5'd6, 3'b100), 2'b01, 0, 32'h102, DM, 0, 0, 0, WB, 0, 0, 32'h00000099, 0);
    step("lh0",  1, ins(5'd6, 3'b001), 2'b01, 0, 32'h100, DM, 0, 0, 0, WB, 0, 0, 32'hFFFFAABB, 0);
    step("lhu2", 1, ins(5'd6, 3'b101), 2'b01, 0, 32'h102, DM, 0, 0, 0, WB, 0, 0, 32'h00008899, 0);
    step("lw",   1, ins(5'd6, 3'b010), 2'b01, 0, 32'h100, DM, 0, 0, 0, WB, 0, 0, 32'h8899AABB, 0);
    step("lh3",  1, ins(5'd6, 3'b001), 2'b01, 0, 32'h103, DM, 0, 0, 0, WB, 0, 0, 32'hFFFF8899, 0);
    step("lb3",  1, ins(5'd6, 3'b000), 2'b01, 0, 32'h103, DM, 0, 0, 0, WB, 0, 0, 32'hFFFFFF88, 0);
    step("lbu0", 1, ins(5'd6, 3'b100), 2'b01, 0, 32'h100, DM, 0, 0, 0, WB, 0, 0, 32'h000000BB, 0);
    step("ld_f3", 1, ins(5'd6, 3'b011), 2'b01, 0, 32'h101, DM, 0, 0, 0, WB, 0, 0, DM, 0);
    // load committed to x6, checked by bypass then storage
    step("lb_x6", 1, ins(5'd6, 3'b000), 2'b01, 1, 32'h101, DM, 0, 6, 6, ALL,
         32'hFFFFFFAA, 32'hFFFFFFAA, 32'hFFFFFFAA, 1);
    step("rd_x6", 1, 32'd0, 2'b00, 0, 0, 0, 0, 6, 5, RD, 32'hFFFFFFAA, 32'hDEADBEEF, 0, 0);

    step("x0_wr", 1, ins(5'd0, 3'd0), 2'b00, 1, 32'h1234, 0, 0, 0, 0, ALL, 0, 0, 32'h1234, 0);
    step("x0_rd", 1, 32'd0, 2'b00, 0, 0, 0, 0, 0, 0, RD, 0, 0, 0, 0);

    step("pc4_x1", 1, ins(5'd1, 3'd0), 2'b10, 1, 32'hAAAA, 0, 32'h104, 1, 0, ALL,
         32'h104, 0, 32'h104, 1);
    step("rsv_x2", 1, ins(5'd2, 3'd0), 2'b11, 1, 32'hFFFF, DM, 32'h108, 1, 2, ALL,
         32'h104, 0, 0, 1);
    step("rd_x12", 1, 32'd0, 2'b00, 0, 0, 0, 0, 1, 2, RD, 32'h104, 0, 0, 0);

    step("b2b_a", 1, ins(5'd3, 3'd0), 2'b00, 1, 32'h111, 0, 0, 3, 0, ALL, 32'h111, 0, 32'h111, 1);
    step("b2b_b", 1, ins(5'd3, 3'd0), 2'b00, 1, 32'h222, 0, 0, 3, 3, ALL,
         32'h222, 32'h222, 32'h222, 1);
    step("b2b_rd", 1, 32'd0, 2'b00, 0, 0, 0, 0, 3, 0, RD, 32'h222, 0, 0, 0);

    // fresh reset, then 5 instructions with 2 bubbles
    step("rst2", 0, 32'd0, 2'b00, 0, 0, 0, 0, 3, 5, RD, 0, 0, 0, 0);
    step("r_i1", 1, ins(5'd4, 3'd0), 2'b00, 1, 32'h44, 0, 0, 4, 4, ALL, 32'h44, 32'h44, 32'h44, 1);
    step("r_i2", 1, ins(5'd8, 3'd0), 2'b00, 1, 32'h88, 0, 0, 4, 3, RD, 32'h44, 0, 0, 1);
    step("r_bub", 1, 32'd0, 2'b00, 1, 32'h99, 0, 0, 8, 0, RD, 32'h88, 0, 0, 0);
    step("r_i3", 1, ins(5'd9, 3'd0), 2'b00, 0, 0, 0, 0, 0, 0, RD, 0, 0, 0, 0);
    step("r_bub", 1, 32'd0, 2'b00, 0, 0, 0, 0, 0, 0, RD, 0, 0, 0, 0);
    step("r_i4", 1, ins(5'd9, 3'd0), 2'b00, 0, 0, 0, 0, 0, 0, RD, 0, 0, 0, 0);
    step("r_i5", 1, ins(5'd9, 3'd0), 2'b00, 0, 0, 0, 0, 8, 4, RD, 32'h88, 32'h44, 0, 0);
    step("r_cnt", 1, 32'd0, 2'b00, 0, 0, 0, 0, 8, 4, RD, 32'h88, 32'h44, 0, 0);
    begin
      exp_t e;
      e.name = "retire5"; e.m = 5'b10000; e.rs1 = 0; e.rs2 = 0; e.wbd = 0; e.we = 0;
      e.rc = 64'd5;
      q.push_back(e);
    end

    // mid-run reset clears state immediately; bypass suppressed
    step("mid_rst", 0, ins(5'd4, 3'd0), 2'b00, 1, 32'h77, 0, 0, 4, 8, ALL, 0, 0, 32'h77, 0);
    step("post_rs", 1, 32'd0, 2'b00, 0, 0, 0, 0, 4, 8, RD, 0, 0, 0, 0);

    begin
      int budget;
      budget = 0;
      while (q.size() > 0 && budget < 20) begin
        @(posedge clk);
        budget++;
      end
      @(posedge clk);
      if (q.size() > 0) begin
        checks++; errors++;
        $display("FAIL drain queue left %0d want 0", q.size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
